// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared states and command constants for the UART command link
package uart_link_pkg;

  typedef enum logic [2:0] {
    S_STARTUP      = 3'd0,
    S_IDLE         = 3'd1,
    S_SEND         = 3'd2,
    S_TX_WAIT_BUSY = 3'd3,
    S_TX_RUN       = 3'd4,
    S_WAIT_ACK     = 3'd5,
    S_RESP         = 3'd6
  } link_state_e;

  localparam logic [2:0] ST_STARTUP      = S_STARTUP;
  localparam logic [2:0] ST_IDLE         = S_IDLE;
  localparam logic [2:0] ST_SEND         = S_SEND;
  localparam logic [2:0] ST_TX_WAIT_BUSY = S_TX_WAIT_BUSY;
  localparam logic [2:0] ST_TX_RUN       = S_TX_RUN;
  localparam logic [2:0] ST_WAIT_ACK     = S_WAIT_ACK;
  localparam logic [2:0] ST_RESP         = S_RESP;

  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h3C;

  localparam logic [3:0] CMD_TURN_ON  = 4'h6;
  localparam logic [3:0] CMD_TURN_OFF = 4'hD;
  localparam logic [7:0] CMD_TOGGLE   = 8'h9D;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_cmd_link_if.sv
// rtl/uart_cmd_link_if.sv - command request / response handshake between control logic and the link
interface uart_cmd_link_if;

  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       rsp_ok;
  logic [3:0] rsp_retries;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, rsp_valid, rsp_ok, rsp_retries
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, rsp_valid, rsp_ok, rsp_retries
  );

endinterface

// File: rtl/uart_link_timer.sv
// rtl/uart_link_timer.sv - loadable down-counter with zero flag, holds at zero
module uart_link_timer #(
  parameter int unsigned W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_link.sv
// rtl/uart_cmd_link.sv - UART command/ACK link: start-up hold, one command per request,
// ACK timeout with bounded resends and a per-command result.
module uart_cmd_link
  import uart_link_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES     = 48000000,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 4800,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter logic [7:0]  ACK_BYTE           = ACK_BYTE_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  uart_cmd_link_if.slave cmd_if,
  output logic           link_ready_o,
  output logic           uart_reset_o,
  output logic           tx_start_o,
  output logic [7:0]     tx_data_o,
  input  logic           tx_busy_i,
  input  logic           rx_done_i,
  input  logic [7:0]     rx_data_i,
  input  logic           rx_parity_error_i,
  output logic [7:0]     stray_cnt_o
);

  localparam int unsigned TMR_MAX = max_u(STARTUP_CYCLES, ACK_TIMEOUT_CYCLES);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
  // Loading N-1 makes the zero flag appear exactly N cycles after the load decision.
  localparam logic [TMR_W-1:0] STARTUP_LOAD = TMR_W'(STARTUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] ACK_LOAD     = TMR_W'(ACK_TIMEOUT_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [3:0] retry_q, retry_d;
  logic       rsp_ok_q, rsp_ok_d;
  logic [3:0] rsp_retries_q, rsp_retries_d;
  logic       link_ready_q, link_ready_d;
  logic       uart_reset_q, uart_reset_d;
  logic [7:0] stray_q, stray_d;

  logic tmr_load, tmr_en, tmr_zero;
  logic good_ack, ack_hit;

  uart_link_timer #(
    .W         (TMR_W),
    .RESET_VAL (STARTUP_LOAD)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (ACK_LOAD),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  assign good_ack = rx_done_i && (rx_data_i == ACK_BYTE) && !rx_parity_error_i;

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    retry_d       = retry_q;
    rsp_ok_d      = rsp_ok_q;
    rsp_retries_d = rsp_retries_q;
    link_ready_d  = link_ready_q;
    uart_reset_d  = uart_reset_q;
    tmr_load      = 1'b0;
    tmr_en        = 1'b0;
    ack_hit       = 1'b0;

    case (state_q)
      ST_STARTUP: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d      = ST_IDLE;
          uart_reset_d = 1'b0;
          link_ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (cmd_if.cmd_valid) begin
          tx_data_d = cmd_if.cmd_data;
          retry_d   = 4'd0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_TX_WAIT_BUSY;
      end
      ST_TX_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = ST_TX_RUN;
        end
      end
      ST_TX_RUN: begin
        if (!tx_busy_i) begin
          tmr_load = 1'b1;
          state_d  = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        tmr_en = 1'b1;
        // A good ACK wins over a simultaneous timer expiry.
        if (good_ack) begin
          ack_hit       = 1'b1;
          rsp_ok_d      = 1'b1;
          rsp_retries_d = retry_q;
          state_d       = ST_RESP;
        end else if (tmr_zero) begin
          if (retry_q < 4'(MAX_RETRIES)) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_SEND;
          end else begin
            rsp_ok_d      = 1'b0;
            rsp_retries_d = retry_q;
            state_d       = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_STARTUP;
      end
    endcase
  end

  always_comb begin
    stray_d = stray_q;
    if (rx_done_i && !ack_hit && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_STARTUP;
      tx_data_q     <= 8'h00;
      retry_q       <= 4'd0;
      rsp_ok_q      <= 1'b0;
      rsp_retries_q <= 4'd0;
      link_ready_q  <= 1'b0;
      uart_reset_q  <= 1'b1;
      stray_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      retry_q       <= retry_d;
      rsp_ok_q      <= rsp_ok_d;
      rsp_retries_q <= rsp_retries_d;
      link_ready_q  <= link_ready_d;
      uart_reset_q  <= uart_reset_d;
      stray_q       <= stray_d;
    end
  end

  assign cmd_if.cmd_ready   = (state_q == ST_IDLE);
  assign cmd_if.rsp_valid   = (state_q == ST_RESP);
  assign cmd_if.rsp_ok      = rsp_ok_q;
  assign cmd_if.rsp_retries = rsp_retries_q;
  assign tx_start_o         = (state_q == ST_SEND);
  assign tx_data_o          = tx_data_q;
  assign link_ready_o       = link_ready_q;
  assign uart_reset_o       = uart_reset_q;
  assign stray_cnt_o        = stray_q;

endmodule
